// File: rtl/sha3_sponge_ctrl.sv
// Sequencing FSM for the SHA3-256 sponge: absorbs 17-lane rate blocks, steps Keccak-f rounds,
// and presents the digest. Holds no data; drives the datapath with strobes and a round index.
module sha3_sponge_ctrl #(
    parameter int unsigned ROUNDS_PER_CYC = 1,
    parameter int unsigned NUM_ROUNDS     = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_in_valid,
    input  logic       i_in_done,
    output logic       o_in_ready,
    output logic       o_absorb_en,
    output logic       o_absorb_first,
    output logic       o_perm_en,
    output logic [4:0] o_round_idx,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic       o_busy
);

    // Legal rates are exactly the divisors of 24.
    if (NUM_ROUNDS != 24 || ROUNDS_PER_CYC == 0 || ROUNDS_PER_CYC > 24 ||
        (24 % ROUNDS_PER_CYC) != 0) begin : g_param_err
        $error("sha3_sponge_ctrl: illegal ROUNDS_PER_CYC/NUM_ROUNDS");
    end

    localparam logic [4:0] RoundStep = 5'(ROUNDS_PER_CYC);
    localparam logic [4:0] RoundEnd  = 5'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        StIdle,
        StPerm,
        StSqueeze
    } state_t;

    state_t     r_state;
    logic [4:0] r_cnt;
    logic       r_first_blk;
    logic       r_last_blk;
    logic       r_in_ready;
    logic       r_out_valid;
    logic       r_perm_en;
    logic       r_busy;
    logic [4:0] w_cnt_nxt;
    logic       w_acc;

    assign w_cnt_nxt = r_cnt + RoundStep;
    assign w_acc     = i_in_valid & r_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= 5'd0;
            r_first_blk <= 1'b1;
            r_last_blk  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_perm_en   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_acc) begin
                        r_state     <= StPerm;
                        r_last_blk  <= i_in_done;
                        r_first_blk <= 1'b0;
                        r_cnt       <= 5'd0;
                        r_in_ready  <= 1'b0;
                        r_perm_en   <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                StPerm: begin
                    if (w_cnt_nxt == RoundEnd) begin
                        r_cnt     <= 5'd0;
                        r_perm_en <= 1'b0;
                        if (r_last_blk) begin
                            r_state     <= StSqueeze;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state    <= StIdle;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b0;
                        end
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                StSqueeze: begin
                    if (i_out_ready) begin
                        r_state     <= StIdle;
                        r_first_blk <= 1'b1;
                        r_last_blk  <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_cnt       <= 5'd0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_perm_en   <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready     = r_in_ready;
    assign o_out_valid    = r_out_valid;
    assign o_perm_en      = r_perm_en;
    assign o_round_idx    = r_cnt;
    assign o_busy         = r_busy;
    assign o_absorb_en    = w_acc;
    assign o_absorb_first = w_acc & r_first_blk;

endmodule

// File: tb/tb_sha3_sponge_ctrl.sv
// Randomized scoreboard bench: two controllers (1 and 4 rounds/cycle) run side by side against a
// timeline model built from accept times, permutation length and digest handshakes.
module tb_sha3_sponge_ctrl;

  localparam int NI       = 2;
  localparam int NCYC     = 4000;
  localparam int RST_AT   = 36;
  localparam int DRAIN_TO = 16;

  typedef struct packed {
    logic       in_ready;
    logic       out_valid;
    logic       perm_en;
    logic       busy;
    logic       absorb_en;
    logic       absorb_first;
    logic [4:0] round_idx;
  } exp_t;

  typedef exp_t [NI-1:0] pair_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid     [NI];
  logic       in_done      [NI];
  logic       out_ready    [NI];
  logic       in_ready     [NI];
  logic       absorb_en    [NI];
  logic       absorb_first [NI];
  logic       perm_en      [NI];
  logic [4:0] round_idx    [NI];
  logic       out_valid    [NI];
  logic       busy         [NI];

  pair_t sb_q[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sha3_sponge_ctrl #(
      .ROUNDS_PER_CYC((g == 0) ? 1 : 4),
      .NUM_ROUNDS    (24)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_in_valid    (in_valid[g]),
      .i_in_done     (in_done[g]),
      .o_in_ready    (in_ready[g]),
      .o_absorb_en   (absorb_en[g]),
      .o_absorb_first(absorb_first[g]),
      .o_perm_en     (perm_en[g]),
      .o_round_idx   (round_idx[g]),
      .o_out_valid   (out_valid[g]),
      .i_out_ready   (out_ready[g]),
      .o_busy        (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t sample(int k);
    exp_t s;
    s.in_ready     = in_ready[k];
    s.out_valid    = out_valid[k];
    s.perm_en      = perm_en[k];
    s.busy         = busy[k];
    s.absorb_en    = absorb_en[k];
    s.absorb_first = absorb_first[k];
    s.round_idx    = round_idx[k];
    return s;
  endfunction

  // Reset values: only in_ready is high.
  task automatic check_reset_state();
    exp_t rst_want;
    exp_t got;
    rst_want          = '0;
    rst_want.in_ready = 1'b1;
    for (int k = 0; k < NI; k++) begin
      got = sample(k);
      total++;
      if (got !== rst_want) begin
        bad++;
        $display("FAIL reset state inst=%0d got=%b want=%b", k, got, rst_want);
      end
    end
  endtask

  // Monitor: one expectation pair per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      pair_t want;
      exp_t  got;
      want = sb_q.pop_front();
      for (int k = 0; k < NI; k++) begin
        got = sample(k);
        total++;
        if (got !== want[k]) begin
          bad++;
          $display("FAIL outputs cyc=%0d inst=%0d got{rdy,ov,pe,busy,ae,af,idx}=%b want=%b",
                   cyc, k, got, want[k]);
        end
      end
    end
  end

  // Model per instance: permutation occupies cycles acc+1..acc+P after an accept;
  // a final block then owes a digest until it is handshaken.
  int busy_until [NI];
  int acc_t      [NI];
  bit pending    [NI];
  bit first      [NI];

  initial begin
    pair_t e;
    int    rpc;
    int    p;
    bit    rst_cyc;
    int    wait_cyc;

    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      in_valid[k]   = 1'b0;
      in_done[k]    = 1'b0;
      out_ready[k]  = 1'b0;
      busy_until[k] = -1;
      acc_t[k]      = 0;
      pending[k]    = 1'b0;
      first[k]      = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();

    for (int t = 0; t < NCYC; t++) begin
      @(posedge clk);
      #1;
      cyc     = t;
      rst_cyc = (t == RST_AT) || (t > 200 && $urandom_range(0, 299) == 0);
      rst_n   = !rst_cyc;
      for (int k = 0; k < NI; k++) begin
        rpc = (k == 0) ? 1 : 4;
        p   = 24 / rpc;
        if (rst_cyc) begin
          in_valid[k]  = 1'b0;
          in_done[k]   = 1'b0;
          out_ready[k] = 1'b0;
        end else if (t < RST_AT) begin
          in_valid[k]  = 1'b1;
          in_done[k]   = 1'b0;
          out_ready[k] = 1'b1;
        end else if (t < RST_AT + 4) begin
          in_valid[k]  = 1'b1;
          in_done[k]   = 1'b1;
          out_ready[k] = 1'b1;
        end else begin
          in_valid[k]  = ($urandom_range(0, 3) != 0);
          in_done[k]   = ($urandom_range(0, 2) == 0);
          out_ready[k] = ($urandom_range(0, 3) != 0);
        end

        e[k] = '0;
        if (rst_cyc) begin
          e[k].in_ready = 1'b1;
          busy_until[k] = -1;
          pending[k]    = 1'b0;
          first[k]      = 1'b1;
        end else if (t <= busy_until[k]) begin
          e[k].perm_en   = 1'b1;
          e[k].busy      = 1'b1;
          e[k].round_idx = 5'((t - acc_t[k] - 1) * rpc);
        end else if (pending[k]) begin
          e[k].out_valid = 1'b1;
          e[k].busy      = 1'b1;
          if (out_ready[k]) begin
            pending[k] = 1'b0;
            first[k]   = 1'b1;
          end
        end else begin
          e[k].in_ready     = 1'b1;
          e[k].absorb_en    = in_valid[k];
          e[k].absorb_first = in_valid[k] & first[k];
          if (in_valid[k]) begin
            acc_t[k]      = t;
            busy_until[k] = t + p;
            pending[k]    = in_done[k];
            first[k]      = 1'b0;
          end
        end
      end
      sb_q.push_back(e);
    end

    // Bounded wait for the monitor to consume every expectation.
    wait_cyc = 0;
    while (sb_q.size() > 0 && wait_cyc < DRAIN_TO) begin
      @(posedge clk);
      wait_cyc++;
    end
    @(posedge clk);
    if (sb_q.size() != 0 || total != NCYC * NI + NI) begin
      bad++;
      $display("FAIL drain timeout: left=%0d compares=%0d want=%0d",
               sb_q.size(), total, NCYC * NI + NI);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad == 0) $display("PASS");
    else          $display("FAIL");
    $finish;
  end

endmodule
